argmax_stream: RTL and testbench



---
 rtl/argmax_pkg.sv | 20 ++
 rtl/argmax_cmp.sv | 27 ++
 rtl/argmax_stream.sv | 111 +++++++++++
 tb/tb_argmax_stream.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/argmax_pkg.sv
// Shared types and helpers for the streaming argmax block and its
// comparator.
package argmax_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_HOLD
  } state_t;

  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int N_MAX_DEF = 16;
  localparam int LEN_W_DEF = idx_width(N_MAX_DEF) + 1;

  typedef logic [LEN_W_DEF-1:0] len_t;

endpackage

// File: rtl/argmax_cmp.sv
// Update-enable for a running maximum. take is high when cand should
// replace cur.
module argmax_cmp #(
  parameter int W        = 8,
  parameter bit SIGNED   = 1'b0,
  parameter bit TIE_LAST = 1'b0
) (
  input  logic [W-1:0] cand,
  input  logic [W-1:0] cur,
  output logic         take
);

  logic gt;
  logic eq;

  generate
    if (SIGNED) begin : g_sgn
      assign gt = $signed(cand) > $signed(cur);
    end else begin : g_uns
      assign gt = cand > cur;
    end
  endgenerate

  assign eq   = cand == cur;
  assign take = gt | (TIE_LAST & eq);

endmodule

// File: rtl/argmax_stream.sv
// Streaming argmax: one element per cycle in, one held
// max/index/length result out per vector.
module argmax_stream
  import argmax_pkg::*;
#(
  parameter int W        = 8,
  parameter int N_MAX    = 16,
  parameter int IDX_W    = idx_width(N_MAX),
  parameter bit SIGNED   = 1'b0,
  parameter bit TIE_LAST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_max,
  output logic [IDX_W-1:0] out_idx,
  output logic [IDX_W:0]   out_len,
  output logic             out_ovf
);

  localparam logic [IDX_W:0] LAST_CNT = (IDX_W+1)'(N_MAX - 1);
  localparam logic [IDX_W:0] ONE      = (IDX_W+1)'(1);

  state_t           state;
  logic [W-1:0]     max_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W:0]   cnt_q;
  logic             ovf_q;
  logic             vld_q;
  logic             take;

  argmax_cmp #(
    .W        (W),
    .SIGNED   (SIGNED),
    .TIE_LAST (TIE_LAST)
  ) u_cmp (
    .cand (in_data),
    .cur  (max_q),
    .take (take)
  );

  assign in_ready  = state != S_HOLD;
  assign out_valid = vld_q;
  assign out_max   = max_q;
  assign out_idx   = idx_q;
  assign out_len   = cnt_q;
  assign out_ovf   = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      max_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            max_q <= in_data;
            idx_q <= '0;
            cnt_q <= ONE;
            ovf_q <= 1'b0;
            if (in_last) begin
              state <= S_HOLD;
              vld_q <= 1'b1;
            end else begin
              state <= S_ACC;
            end
          end
        end
        S_ACC: begin
          if (in_valid) begin
            if (take) begin
              max_q <= in_data;
              idx_q <= cnt_q[IDX_W-1:0];
            end
            cnt_q <= cnt_q + ONE;
            // in_last wins over the length limit
            if (in_last) begin
              state <= S_HOLD;
              vld_q <= 1'b1;
              ovf_q <= 1'b0;
            end else if (cnt_q == LAST_CNT) begin
              state <= S_HOLD;
              vld_q <= 1'b1;
              ovf_q <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            state <= S_IDLE;
            vld_q <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          vld_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_argmax_stream.sv
// Randomised bench for argmax_stream: three configurations share one
// input stream and are checked against a plain max/argmax model.
module tb_argmax_stream;

  localparam int W  = 8;
  localparam int NM = 16;
  localparam int IW = 4;

  localparam bit SG [3] = '{1'b0, 1'b1, 1'b0};
  localparam bit TL [3] = '{1'b0, 1'b0, 1'b1};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_last = 1'b0;
  logic          out_ready = 1'b0;

  logic          rdy  [3];
  logic          vld  [3];
  logic [W-1:0]  omax [3];
  logic [IW-1:0] oidx [3];
  logic [IW:0]   olen [3];
  logic          oovf [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_dut
      argmax_stream #(
        .W        (W),
        .N_MAX    (NM),
        .SIGNED   (SG[g]),
        .TIE_LAST (TL[g])
      ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (rdy[g]),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (vld[g]),
        .out_ready (out_ready),
        .out_max   (omax[g]),
        .out_idx   (oidx[g]),
        .out_len   (olen[g]),
        .out_ovf   (oovf[g])
      );
    end
  endgenerate

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int key(input logic [W-1:0] v, input bit s);
    return s ? int'($signed(v)) : int'(v);
  endfunction

  // Max value first, then first or last position holding it.
  function automatic void model(input logic [W-1:0] v[$], input bit wl,
                                input bit s, input bit tl,
                                output logic [W-1:0] mx, output int ix,
                                output int ln, output bit ov);
    int m;
    m = key(v[0], s);
    foreach (v[i]) if (key(v[i], s) > m) m = key(v[i], s);
    ix = -1;
    foreach (v[i]) begin
      if (key(v[i], s) == m && (tl || ix < 0)) ix = i;
    end
    mx = v[ix];
    ln = v.size();
    ov = !wl;
  endfunction

  task automatic send(input logic [W-1:0] d, input bit l, input int gap);
    int n;
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = W'($urandom);
      in_last  = 1'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    n = 0;
    while (!rdy[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("rdy_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_vec(input logic [W-1:0] v[$], input bit wl,
                          input int maxgap);
    foreach (v[i]) begin
      send(v[i], wl && (i == v.size() - 1),
           (i == 0) ? 0 : $urandom_range(0, maxgap));
    end
  endtask

  // Called at posedge+1 right after the final accept.
  task automatic check_res(input logic [W-1:0] v[$], input bit wl,
                           input int hold, input string tag);
    logic [W-1:0] mx [3];
    int ix [3];
    int ln [3];
    bit ov [3];
    for (int k = 0; k < 3; k++) begin
      model(v, wl, SG[k], TL[k], mx[k], ix[k], ln[k], ov[k]);
      chk({tag, "_lat"}, 32'(vld[k]), 1);
    end
    out_ready = 1'b0;
    repeat (hold) begin
      @(negedge clk);
      chk({tag, "_hold_rdy"}, 32'(rdy[0]), 0);
      chk({tag, "_hold_vld"}, 32'(vld[0]), 1);
      chk({tag, "_hold_max"}, 32'(omax[0]), 32'(mx[0]));
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk({tag, "_max"}, 32'(omax[k]), 32'(mx[k]));
      chk({tag, "_idx"}, 32'(oidx[k]), 32'(ix[k]));
      chk({tag, "_len"}, 32'(olen[k]), 32'(ln[k]));
      chk({tag, "_ovf"}, 32'(oovf[k]), 32'(ov[k]));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_drop"}, 32'(vld[0]), 0);
    chk({tag, "_rdy"}, 32'(rdy[0]), 1);
  endtask

  initial begin
    logic [W-1:0] q[$];
    int len;
    bit wl;

    #12;
    chk("rst_vld", 32'(vld[0]), 0);
    chk("rst_max", 32'(omax[0]), 0);
    chk("rst_len", 32'(olen[0]), 0);
    chk("rst_rdy", 32'(rdy[0]), 1);
    @(negedge clk);
    rst_n = 1'b1;

    q = '{8'h01, 8'h8F, 8'h49, 8'h09, 8'h8F,
          8'h49, 8'hF1, 8'h9F, 8'h69, 8'h4D};
    send_vec(q, 1'b1, 0);
    chk("t1_umax", 32'(omax[0]), 32'hF1);
    chk("t1_uidx", 32'(oidx[0]), 6);
    chk("t2_smax", 32'(omax[1]), 32'h69);
    chk("t2_sidx", 32'(oidx[1]), 8);
    check_res(q, 1'b1, 0, "t1");

    q = '{8'h0C, 8'h0D, 8'h0D, 8'h04};
    send_vec(q, 1'b1, 1);
    chk("t3_first", 32'(oidx[0]), 1);
    chk("t3_last", 32'(oidx[2]), 2);
    check_res(q, 1'b1, 0, "t3");

    q = {};
    for (int i = 0; i < NM; i++) q.push_back(W'($urandom_range(0, 8'h7D)));
    q[15] = 8'h7E;
    send_vec(q, 1'b0, 0);
    chk("t4_idx", 32'(oidx[0]), 15);
    chk("t4_ovf", 32'(oovf[0]), 1);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h22;
    in_last  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t4_block", 32'(rdy[0]), 0);
      chk("t4_keep", 32'(olen[0]), 16);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("t4_idle", 32'(vld[0]), 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    q = '{8'h22};
    check_res(q, 1'b1, 0, "t4b");

    q = '{8'h10, 8'hA0, 8'h20};
    send_vec(q, 1'b1, 0);
    check_res(q, 1'b1, 5, "t5a");
    q = '{8'h33};
    send_vec(q, 1'b1, 0);
    chk("t5_len", 32'(olen[0]), 1);
    check_res(q, 1'b1, 0, "t5b");

    send(8'h40, 1'b0, 0);
    send(8'h50, 1'b0, 0);
    send(8'h60, 1'b0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("t6_max", 32'(omax[k]), 0);
      chk("t6_len", 32'(olen[k]), 0);
      chk("t6_idx", 32'(oidx[k]), 0);
      chk("t6_vld", 32'(vld[k]), 0);
    end
    #1;
    rst_n = 1'b1;
    q = '{8'h05, 8'h07};
    send_vec(q, 1'b1, 0);
    chk("t6_nidx", 32'(oidx[0]), 1);
    chk("t6_nlen", 32'(olen[0]), 2);
    check_res(q, 1'b1, 0, "t6");

    for (int r = 0; r < 40; r++) begin
      len = $urandom_range(1, NM);
      q = {};
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 1) == 1) q.push_back(W'($urandom_range(0, 3)));
        else q.push_back(W'($urandom));
      end
      wl = (len < NM) ? 1'b1 : 1'($urandom_range(0, 1));
      send_vec(q, wl, 2);
      check_res(q, wl, $urandom_range(0, 3), "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
